pooling_layer_row_packer: RTL and testbench
===========================================

Name: pooling_layer_row_packer

Overview:
Producer end of the pooling input-cache interface. Accepts convolution results serially, one DATA_WIDTH word per cycle, through a valid/ready handshake. Packs INPUT_SIZE words into one row bus and delivers it with a single-cycle row_fin pulse, which drives kernel_calc_fin of the pooling input cache. A hold register decouples input assembly from downstream backpressure. The block also tracks row position within a feature map and flags the frame's last row.

Parameters:
DATA_WIDTH, 32, word width (IEEE-754 single; treated as opaque bits)
INPUT_SIZE, 6, words per packed row
KERNEL_SIZE, 2, pooling window width; INPUT_SIZE must be a multiple of it (elaboration-time check)
ROWS, 6, rows per feature map
CNT_W, $clog2(INPUT_SIZE), word-counter width
ROW_W, $clog2(ROWS), row-counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
frame_abort  in  1  synchronous clear of all packing/row state
in_data  in  DATA_WIDTH  serial convolution result
in_valid  in  1  in_data valid
in_ready  out  1  block can accept in_data this cycle
row_ready  in  1  downstream can take a row
row_data  out  INPUT_SIZE*DATA_WIDTH  packed row; first word received sits in [INPUT_SIZE*DATA_WIDTH-1 -: DATA_WIDTH]
row_valid  out  1  hold register holds a complete row
row_fin  out  1  row_valid & row_ready; single-cycle transfer pulse (drives kernel_calc_fin)
row_idx  out  ROW_W  index of the row currently in hold (0..ROWS-1)
frame_fin  out  1  pulse coincident with row_fin of row ROWS-1

Behaviour:
- Reset (rst=1, async): word count=0, assembly buffer=0, hold register=0, row_valid=0, row_idx=0. row_fin=0, frame_fin=0, and in_ready=1 after release.
- Input accept occurs when in_valid & in_ready. The word is written to slot cnt, MSB-first: slot k occupies bits [(INPUT_SIZE-k)*DATA_WIDTH-1 -: DATA_WIDTH]. cnt then increments.
- in_ready = (cnt != INPUT_SIZE-1) | ~row_valid | row_ready. The last word of a row is refused only while the hold register is occupied and not draining.
- Completion: accepting the word at cnt=INPUT_SIZE-1 does three things on the next edge:
  - copies the assembly buffer plus that word into the hold register;
  - sets row_valid;
  - resets cnt to 0.
- Latency: last word accepted in cycle N gives row_valid=1 in cycle N+1. With row_ready=1, row_fin also pulses in cycle N+1.
- Transfer: when row_fin=1, row_valid clears on the next edge unless a completion happens in the same cycle. In that case the hold register reloads with the new row and row_valid stays 1. Sustained throughput is 1 word/cycle with no bubbles when row_ready is held high.
- row_data is stable while row_valid=1 && row_ready=0. The hold register is unchanged after a transfer until the next completion.
- Row counter: row_idx increments on each row_fin and wraps from ROWS-1 to 0. frame_fin = row_fin & (row_idx==ROWS-1).
- frame_abort (synchronous):
  - clears cnt, row_valid and row_idx; a partially assembled row is discarded;
  - suppresses row_fin and frame_fin that cycle;
  - has in_ready=0 during the abort cycle.
  - rst has priority over frame_abort.
- Reset mid-row discards all partial state. No output pulses are produced until new input arrives.
- in_data is ignored whenever in_valid=0 or in_ready=0.

Decomposition:
- Shared package pooling_pkg holds:
  - DATA_WIDTH, INPUT_SIZE, KERNEL_SIZE, OUTPUT_SIZE(=INPUT_SIZE/KERNEL_SIZE) and ROWS;
  - typedef word_t (logic [DATA_WIDTH-1:0]) and typedef row_t (logic [INPUT_SIZE*DATA_WIDTH-1:0]);
  - the MSB-first slot-index function.
- One natural sub-module: pooling_row_hold_reg. It contains the hold register, row_valid, and the load/drain/simultaneous logic, with ports load, row_in, ready, valid and row_out.

Test Plan:
1. Reset, then feed six words 32'h3F800000, 40000000, 40400000, 40800000, 40A00000, 40C00000 back-to-back with row_ready=1 -> one cycle after the 6th accept: row_fin=1, row_data=3F800000_40000000_40400000_40800000_40A00000_40C00000, row_idx=0.
2. row_ready=0, feed 12 words -> first row held stable and row_valid=1; in_ready drops exactly at the 12th word (cnt=5). Raise row_ready -> row_fin, then the second row is loaded the next cycle.
3. Continuous stream of 36 words with row_ready=1 -> in_ready never low; six row_fin pulses exactly 6 cycles apart; frame_fin on the 6th pulse; row_idx wraps to 0.
4. Simultaneous case: hold full, row_ready rises in the same cycle the last word of the next row is accepted -> row_fin=1 that cycle, row_valid stays 1, hold contains the new row.
5. frame_abort after 3 words of a row (and again while row_valid=1) -> cnt, row_valid and row_idx are 0; no row_fin or frame_fin; the next 6 words produce row_idx=0.
6. Assert rst mid-row with in_valid=1 -> all outputs 0 immediately (asynchronous); after release, a full 6-word row is needed for the next row_fin.

Source files
------------

// File: rtl/pooling_layer_row_packer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : pooling_pkg                                                  |
// | Purpose : Shared sizes, types and slot helper for the pooling row      |
// |           packer (word/row types, MSB-first slot placement).           |
// | Ports   : none (package)                                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package pooling_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int INPUT_SIZE  = 6;
  localparam int KERNEL_SIZE = 2;
  localparam int OUTPUT_SIZE = INPUT_SIZE / KERNEL_SIZE;
  localparam int ROWS        = 6;
  localparam int CNT_W       = $clog2(INPUT_SIZE);
  localparam int ROW_W       = $clog2(ROWS);

  typedef logic [DATA_WIDTH-1:0]            word_t;
  typedef logic [INPUT_SIZE*DATA_WIDTH-1:0] row_t;
  typedef logic [CNT_W-1:0]                 cnt_t;
  typedef logic [ROW_W-1:0]                 ridx_t;

  // Slot k lives at the top of the row for k=0, so the first word received
  // ends up in the most significant position.
  function automatic int slot_lsb(input int k);
    return (INPUT_SIZE - 1 - k) * DATA_WIDTH;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pooling_layer_row_packer_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : pooling_layer_row_packer_if                                  |
// | Purpose : Serial word input plus packed row output of the packer.      |
// | Ports   : in_data/in_valid/in_ready  serial word handshake             |
// |           row_data/row_valid/row_ready/row_fin  packed row handshake   |
// |           row_idx/frame_fin  row position within the feature map       |
// |           modport master = the packer, modport slave = its environment |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
interface pooling_layer_row_packer_if;
  import pooling_pkg::*;

  word_t in_data;
  logic  in_valid;
  logic  in_ready;
  logic  row_ready;
  row_t  row_data;
  logic  row_valid;
  logic  row_fin;
  ridx_t row_idx;
  logic  frame_fin;

  modport master (
    input  in_data, in_valid, row_ready,
    output in_ready, row_data, row_valid, row_fin, row_idx, frame_fin
  );

  modport slave (
    output in_data, in_valid, row_ready,
    input  in_ready, row_data, row_valid, row_fin, row_idx, frame_fin
  );

endinterface
`default_nettype wire

// File: rtl/pooling_layer_row_packer_hold_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : pooling_row_hold_reg                                         |
// | Purpose : One-row output hold register with valid flag. Loads a new    |
// |           row, drains on ready, reloads when both happen together.     |
// | Ports   : clk, rst        clock, async active-high reset               |
// |           clr_i           synchronous clear of the valid flag          |
// |           load_i/row_in_i new complete row                             |
// |           ready_i         downstream takes the held row                |
// |           valid_o/row_out_o held row and its valid flag                |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module pooling_row_hold_reg
  import pooling_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic load_i,
  input  row_t row_in_i,
  input  logic ready_i,
  output logic valid_o,
  output row_t row_out_o
);

  logic valid_q, valid_d;
  row_t row_q,   row_d;

  // Load wins over drain so a simultaneous transfer + completion keeps the
  // register full with the new row.
  always_comb begin
    valid_d = valid_q;
    row_d   = row_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      row_d   = row_in_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      row_q   <= '0;
    end else begin
      valid_q <= valid_d;
      row_q   <= row_d;
    end
  end

  assign valid_o   = valid_q;
  assign row_out_o = row_q;

endmodule
`default_nettype wire

// File: rtl/pooling_layer_row_packer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : pooling_layer_row_packer                                     |
// | Purpose : Packs INPUT_SIZE serial words into one row, hands the row to |
// |           the pooling input cache through a hold register, and tracks  |
// |           the row position within the feature map.                     |
// | Ports   : clk, rst     clock, async active-high reset                  |
// |           frame_abort  synchronous clear of packing and row state      |
// |           bus          master side of pooling_layer_row_packer_if      |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module pooling_layer_row_packer
  import pooling_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic frame_abort,
  pooling_layer_row_packer_if.master bus
);

  localparam cnt_t  LAST_SLOT = cnt_t'(INPUT_SIZE - 1);
  localparam ridx_t LAST_ROW  = ridx_t'(ROWS - 1);

  if (OUTPUT_SIZE * KERNEL_SIZE != INPUT_SIZE) begin : g_size_check
    $error("INPUT_SIZE must be a multiple of KERNEL_SIZE");
  end

  cnt_t  cnt_q,     cnt_d;
  row_t  buf_q,     buf_d;
  ridx_t row_idx_q, row_idx_d;

  logic  w_in_ready;
  logic  w_accept;
  logic  w_complete;
  logic  w_row_valid;
  logic  w_row_fin;
  row_t  w_row_out;

  // The last word is refused only while the hold register is full and not
  // draining; earlier words only touch the assembly buffer.
  assign w_in_ready = ~frame_abort &
                      ((cnt_q != LAST_SLOT) | ~w_row_valid | bus.row_ready);
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_complete = w_accept & (cnt_q == LAST_SLOT);
  assign w_row_fin  = w_row_valid & bus.row_ready & ~frame_abort;

  always_comb begin
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    row_idx_d = row_idx_q;
    if (w_accept) begin
      for (int k = 0; k < INPUT_SIZE; k++) begin
        if (cnt_q == cnt_t'(k)) begin
          buf_d[slot_lsb(k) +: DATA_WIDTH] = bus.in_data;
        end
      end
      cnt_d = w_complete ? '0 : cnt_q + cnt_t'(1);
    end
    if (frame_abort) begin
      cnt_d     = '0;
      row_idx_d = '0;
    end else if (w_row_fin) begin
      row_idx_d = (row_idx_q == LAST_ROW) ? '0 : row_idx_q + ridx_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      buf_q     <= '0;
      row_idx_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      row_idx_q <= row_idx_d;
    end
  end

  // buf_d already carries the final word when the row completes.
  pooling_row_hold_reg u_hold (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (frame_abort),
    .load_i    (w_complete),
    .row_in_i  (buf_d),
    .ready_i   (bus.row_ready),
    .valid_o   (w_row_valid),
    .row_out_o (w_row_out)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.row_data  = w_row_out;
  assign bus.row_valid = w_row_valid;
  assign bus.row_fin   = w_row_fin;
  assign bus.row_idx   = row_idx_q;
  assign bus.frame_fin = w_row_fin & (row_idx_q == LAST_ROW);

endmodule
`default_nettype wire

// File: tb/tb_pooling_layer_row_packer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_pooling_layer_row_packer                                  |
// | Purpose : Directed table-driven bench for pooling_layer_row_packer.    |
// | Ports   : none                                                         |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_pooling_layer_row_packer;
  import pooling_pkg::*;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        rr;
    logic        ab;
    logic        e_ir;
    logic        e_rv;
    logic        e_fin;
    logic [2:0]  e_idx;
    logic        e_ff;
    logic        chk_d;
    row_t        e_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_abort = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];

  localparam row_t ROW1  = 192'h3F800000_40000000_40400000_40800000_40A00000_40C00000;
  localparam row_t ROW_A = 192'hA0000000_A0000001_A0000002_A0000003_A0000004_A0000005;
  localparam row_t ROW_B = 192'hB0000000_B0000001_B0000002_B0000003_B0000004_B0000005;

  pooling_layer_row_packer_if u_if ();

  pooling_layer_row_packer u_dut (
    .clk         (clk),
    .rst         (rst),
    .frame_abort (frame_abort),
    .bus         (u_if.master)
  );

  always #5 clk = ~clk;

  function automatic row_t pack(input logic [31:0] base);
    row_t r;
    for (int k = 0; k < 6; k++) r[(5 - k) * 32 +: 32] = base + 32'(k);
    return r;
  endfunction

  function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic rr,
                              input logic ab, input logic ir, input logic rv,
                              input logic fin, input int idx, input logic ff,
                              input logic cd, input row_t ed);
    vec_t v;
    v.iv = iv; v.d = d; v.rr = rr; v.ab = ab; v.e_ir = ir; v.e_rv = rv;
    v.e_fin = fin; v.e_idx = 3'(idx); v.e_ff = ff; v.chk_d = cd; v.e_data = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drv(input logic iv, input logic [31:0] d, input logic rr, input logic ab);
    @(negedge clk);
    u_if.in_valid  = iv;
    u_if.in_data   = d;
    u_if.row_ready = rr;
    frame_abort    = ab;
    #1;
  endtask

  task automatic chk_out(input string nm, input logic ir, input logic rv, input logic fin,
                         input int idx, input logic ff);
    chk({nm, " in_ready"},  192'(u_if.in_ready),  192'(ir));
    chk({nm, " row_valid"}, 192'(u_if.row_valid), 192'(rv));
    chk({nm, " row_fin"},   192'(u_if.row_fin),   192'(fin));
    chk({nm, " row_idx"},   192'(u_if.row_idx),   192'(idx));
    chk({nm, " frame_fin"}, 192'(u_if.frame_fin), 192'(ff));
  endtask

  task automatic feed6(input logic [31:0] base, input logic rr, input string nm);
    for (int k = 0; k < 6; k++) begin
      drv(1'b1, base + 32'(k), rr, 1'b0);
      chk({nm, " feed row_fin"}, 192'(u_if.row_fin & ~u_if.row_valid), 192'(0));
    end
  endtask

  initial begin
    u_if.in_valid  = 1'b0;
    u_if.in_data   = '0;
    u_if.row_ready = 1'b0;

    // Test 1: first row, row_ready high.
    tbl.push_back(mk(1, 32'h3F800000, 1, 0, 1, 0, 0, 0, 0, 0, '0));
    tbl.push_back(mk(1, 32'h40000000, 1, 0, 1, 0, 0, 0, 0, 0, '0));
    tbl.push_back(mk(1, 32'h40400000, 1, 0, 1, 0, 0, 0, 0, 0, '0));
    tbl.push_back(mk(1, 32'h40800000, 1, 0, 1, 0, 0, 0, 0, 0, '0));
    tbl.push_back(mk(1, 32'h40A00000, 1, 0, 1, 0, 0, 0, 0, 0, '0));
    tbl.push_back(mk(1, 32'h40C00000, 1, 0, 1, 0, 0, 0, 0, 0, '0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 1, 1, 1, 0, 0, 1, ROW1));
    tbl.push_back(mk(0, 32'h0,        1, 0, 1, 0, 0, 1, 0, 1, ROW1));
    // Test 2: backpressure; row A held while row B assembles.
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(1, 32'hA0000000 + 32'(k), 0, 0, 1, 0, 0, 1, 0, 0, '0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1, 32'hB0000000 + 32'(k), 0, 0, 1, 1, 0, 1, 0, 1, ROW_A));
    tbl.push_back(mk(1, 32'hB0000005, 0, 0, 0, 1, 0, 1, 0, 1, ROW_A));
    tbl.push_back(mk(1, 32'hB0000005, 0, 0, 0, 1, 0, 1, 0, 1, ROW_A));
    // Test 4: row_ready rises together with the last word of row B.
    tbl.push_back(mk(1, 32'hB0000005, 1, 0, 1, 1, 1, 1, 0, 1, ROW_A));
    tbl.push_back(mk(0, 32'h0,        0, 0, 1, 1, 0, 2, 0, 1, ROW_B));
    tbl.push_back(mk(0, 32'h0,        1, 0, 1, 1, 1, 2, 0, 1, ROW_B));
    tbl.push_back(mk(0, 32'h0,        1, 0, 1, 0, 0, 3, 0, 0, '0));
    // Abort on an idle cycle clears row_idx.
    tbl.push_back(mk(0, 32'h0,        1, 1, 0, 0, 0, 3, 0, 0, '0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 1, 0, 0, 0, 0, 0, '0));

    // Reset state.
    #12;
    chk("reset row_valid", 192'(u_if.row_valid), 192'(0));
    chk("reset row_data",  u_if.row_data, 192'(0));
    chk("reset row_idx",   192'(u_if.row_idx), 192'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_out("post-reset", 1, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drv(tbl[i].iv, tbl[i].d, tbl[i].rr, tbl[i].ab);
      chk_out($sformatf("vec%0d", i), tbl[i].e_ir, tbl[i].e_rv, tbl[i].e_fin,
              int'(tbl[i].e_idx), tbl[i].e_ff);
      if (tbl[i].chk_d) chk($sformatf("vec%0d row_data", i), u_if.row_data, tbl[i].e_data);
    end

    // Test 3: 36-word stream, one row_fin every 6 cycles, frame_fin on the 6th.
    for (int t = 0; t < 38; t++) begin
      logic fin;
      int   idx;
      fin = (t > 0) && (t % 6 == 0) && (t <= 36);
      idx = (t == 0) ? 0 : ((t - 1) / 6) % 6;
      drv(t < 36, 32'h10000000 + 32'(t), 1'b1, 1'b0);
      chk_out($sformatf("stream t%0d", t), 1, fin, fin, idx, fin && (t == 36));
      if (fin) chk($sformatf("stream t%0d row_data", t), u_if.row_data,
                   pack(32'h10000000 + 32'(t - 6)));
    end

    // Test 5a: abort after 3 words discards the partial row.
    for (int k = 0; k < 3; k++) drv(1'b1, 32'hDEAD0000 + 32'(k), 1'b1, 1'b0);
    drv(1'b1, 32'hDEAD0003, 1'b1, 1'b1);
    chk_out("abort partial", 0, 0, 0, 0, 0);
    feed6(32'hC0000000, 1'b1, "after abort");
    drv(1'b0, '0, 1'b1, 1'b0);
    chk_out("row C", 1, 1, 1, 0, 0);
    chk("row C row_data", u_if.row_data, pack(32'hC0000000));
    // Test 5b: abort while the hold register is full.
    feed6(32'hD0000000, 1'b0, "row D");
    drv(1'b0, '0, 1'b0, 1'b0);
    chk_out("row D held", 1, 1, 0, 1, 0);
    drv(1'b0, '0, 1'b1, 1'b1);
    chk_out("abort full", 0, 1, 0, 1, 0);
    drv(1'b0, '0, 1'b1, 1'b0);
    chk_out("after abort full", 1, 0, 0, 0, 0);
    feed6(32'hE0000000, 1'b1, "row E");
    drv(1'b0, '0, 1'b1, 1'b0);
    chk_out("row E", 1, 1, 1, 0, 0);
    chk("row E row_data", u_if.row_data, pack(32'hE0000000));

    // Test 6: asynchronous reset mid-row with a row held.
    feed6(32'hF0000000, 1'b0, "row F");
    for (int k = 0; k < 3; k++) drv(1'b1, 32'h90000000 + 32'(k), 1'b0, 1'b0);
    chk_out("pre-reset", 1, 1, 0, 1, 0);
    drv(1'b1, 32'h90000003, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("async rst row_valid", 192'(u_if.row_valid), 192'(0));
    chk("async rst row_fin",   192'(u_if.row_fin),   192'(0));
    chk("async rst row_idx",   192'(u_if.row_idx),   192'(0));
    chk("async rst row_data",  u_if.row_data,        192'(0));
    drv(1'b1, 32'h90000004, 1'b1, 1'b0);
    rst = 1'b0;
    u_if.in_valid = 1'b0;
    feed6(32'h80000000, 1'b1, "post rst");
    drv(1'b0, '0, 1'b1, 1'b0);
    chk_out("post rst row", 1, 1, 1, 0, 0);
    chk("post rst row_data", u_if.row_data, pack(32'h80000000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
